// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: entry layout, counter constants, PC field extraction.
// Latency: n/a (package).
// Backpressure: n/a (package).
package bp_pkg;

  // Upper bounds on the module parameters.
  // Table entries are stored at these widths, and the module zero-extends its fields into them.
  localparam int MAX_ADDR_W = 64;
  localparam int MAX_TAG_W  = 32;
  localparam int MAX_CTR_W  = 16;

  typedef struct packed {
    logic                  valid;
    logic [MAX_TAG_W-1:0]  tag;
    logic [MAX_CTR_W-1:0]  ctr;
    logic [MAX_ADDR_W-1:0] target;
  } bp_entry_t;

  // Saturation ceiling of a ctr_w-bit history counter
  function automatic int unsigned ctr_max(input int ctr_w);
    return (32'd1 << ctr_w) - 32'd1;
  endfunction

  // Allocation value: weakly taken (MSB set, all other bits clear)
  function automatic int unsigned ctr_weak_taken(input int ctr_w);
    return 32'd1 << (ctr_w - 1);
  endfunction

  // BTB index: word address bits just above the byte offset
  function automatic int unsigned pc_index(input logic [MAX_ADDR_W-1:0] pc, input int idx_w);
    logic [MAX_ADDR_W-1:0] mask;
    mask = (MAX_ADDR_W'(1) << idx_w) - MAX_ADDR_W'(1);
    return 32'((pc >> 2) & mask);
  endfunction

  // BTB tag: the tag_w bits sitting directly above the index
  function automatic logic [MAX_TAG_W-1:0] pc_tag(input logic [MAX_ADDR_W-1:0] pc,
                                                  input int idx_w, input int tag_w);
    logic [MAX_ADDR_W-1:0] mask;
    mask = (MAX_ADDR_W'(1) << tag_w) - MAX_ADDR_W'(1);
    return MAX_TAG_W'((pc >> (idx_w + 2)) & mask);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup, ID-resolution and statistics signals between the pipeline and the branch predictor.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is sampled or driven every cycle.
interface branch_predictor_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] if_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;

  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [ADDR_W-1:0] upd_pred_target;

  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [31:0]       stat_branches;
  logic [31:0]       stat_mispredicts;

  // Pipeline side
  modport master (
    output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           stat_branches, stat_mispredicts
  );

  // Predictor side
  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    output pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/bp_sat_ctr.sv
// Saturating up/down counter next-state function (no storage).
// Latency: combinational.
// Backpressure: none; simultaneous inc and dec hold the value.
module bp_sat_ctr #(
  parameter int             W   = 2,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic [W-1:0] cnt,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] nxt
);

  // Step toward the requested direction unless already pinned at the rail
  always_comb begin
    nxt = cnt;
    if (inc && !dec && (cnt != MAX)) begin
      nxt = cnt + W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      nxt = cnt - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped tagged BTB with per-entry saturating counters, trained from ID-stage resolution.
// Latency: prediction and mispredict/redirect are combinational; training is visible 1 cycle later.
// Backpressure: none; one lookup and one update accepted every cycle, same-index lookup sees old data.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bp
);

  localparam int              IDX_W    = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX  = CTR_W'(ctr_max(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(ctr_weak_taken(CTR_W));

  bp_entry_t bp_tbl [0:ENTRIES-1];

  logic [IDX_W-1:0]     lk_idx;
  logic [MAX_TAG_W-1:0] lk_tag;
  bp_entry_t            lk_e;
  logic                 lk_hit;
  logic                 lk_taken;

  logic [IDX_W-1:0]     up_idx;
  logic [MAX_TAG_W-1:0] up_tag;
  bp_entry_t            up_e;
  logic                 up_hit;
  logic [CTR_W-1:0]     ctr_nxt;

  logic                 wr_en;
  bp_entry_t            wr_e;

  logic                 mispredict;
  logic [31:0]          stat_br_q;
  logic [31:0]          stat_mis_q;
  logic [31:0]          stat_br_nxt;
  logic [31:0]          stat_mis_nxt;

  // Bits of the wide entry beyond this instance's field widths are never consulted on lookup
  logic                 unused_bits;
  assign unused_bits = ^{lk_e, up_e};

  // ---------------------------------------------------------------- fetch lookup

  assign lk_idx = IDX_W'(pc_index(MAX_ADDR_W'(bp.if_pc), IDX_W));
  assign lk_tag = pc_tag(MAX_ADDR_W'(bp.if_pc), IDX_W, TAG_W);
  assign lk_e   = bp_tbl[lk_idx];

  assign lk_hit   = lk_e.valid && (lk_e.tag == lk_tag);
  assign lk_taken = lk_hit && lk_e.ctr[CTR_W-1];

  assign bp.pred_hit    = lk_hit;
  assign bp.pred_taken  = lk_taken;
  assign bp.pred_target = lk_taken ? lk_e.target[ADDR_W-1:0] : bp.if_pc + ADDR_W'(4);

  // ---------------------------------------------------------------- ID resolution

  // A taken/not-taken disagreement, or both taken but to different targets, needs a redirect
  assign mispredict = bp.upd_valid &&
                      ((bp.upd_taken != bp.upd_pred_taken) ||
                       (bp.upd_taken && bp.upd_pred_taken && (bp.upd_target != bp.upd_pred_target)));

  assign bp.mispredict  = mispredict;
  assign bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + ADDR_W'(4);

  // ---------------------------------------------------------------- training

  assign up_idx = IDX_W'(pc_index(MAX_ADDR_W'(bp.upd_pc), IDX_W));
  assign up_tag = pc_tag(MAX_ADDR_W'(bp.upd_pc), IDX_W, TAG_W);
  assign up_e   = bp_tbl[up_idx];
  assign up_hit = up_e.valid && (up_e.tag == up_tag);

  bp_sat_ctr #(
    .W   (CTR_W),
    .MAX (CTR_MAX)
  ) u_hist_ctr (
    .cnt (up_e.ctr[CTR_W-1:0]),
    .inc (bp.upd_taken),
    .dec (!bp.upd_taken),
    .nxt (ctr_nxt)
  );

  // Build the replacement entry: train on hit, allocate weakly-taken on a taken miss
  always_comb begin
    wr_en = 1'b0;
    wr_e  = up_e;
    if (bp.upd_valid) begin
      if (up_hit) begin
        wr_en   = 1'b1;
        wr_e.ctr = MAX_CTR_W'(ctr_nxt);
        if (bp.upd_taken) begin
          wr_e.target = MAX_ADDR_W'(bp.upd_target);
        end
      end else if (bp.upd_taken) begin
        wr_en       = 1'b1;
        wr_e.valid  = 1'b1;
        wr_e.tag    = up_tag;
        wr_e.ctr    = MAX_CTR_W'(CTR_WEAK);
        wr_e.target = MAX_ADDR_W'(bp.upd_target);
      end
    end
  end

  // Table storage; reset wipes every entry immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bp_tbl[i] <= '0;
      end
    end else if (wr_en) begin
      bp_tbl[up_idx] <= wr_e;
    end
  end

  // ---------------------------------------------------------------- statistics

  bp_sat_ctr #(
    .W (32)
  ) u_stat_br (
    .cnt (stat_br_q),
    .inc (bp.upd_valid),
    .dec (1'b0),
    .nxt (stat_br_nxt)
  );

  bp_sat_ctr #(
    .W (32)
  ) u_stat_mis (
    .cnt (stat_mis_q),
    .inc (mispredict),
    .dec (1'b0),
    .nxt (stat_mis_nxt)
  );

  // Saturating resolved-branch and mispredict counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q  <= stat_br_nxt;
      stat_mis_q <= stat_mis_nxt;
    end
  end

  assign bp.stat_branches    = stat_br_q;
  assign bp.stat_mispredicts = stat_mis_q;

endmodule
